usb_pkt_encoder: RTL and testbench
==================================

# usb_pkt_encoder

Parametrised successor to the fixed-format bitstream encoder. It serialises a full USB packet LSB-first, one bit per unpaused clock: SYNC, PID, then the fields that packet type needs, hardware-generated CRC5/CRC16, and an EOP marker. Data payload length is selectable per packet up to `MAX_BYTES`. It sits upstream of the bit-stuffer/NRZI stage, which throttles it through `pause`.

## Interface
- `MAX_BYTES`, default 8: maximum payload bytes per data packet, range 1..64.
- `NB_W`, default `$clog2(MAX_BYTES+1)`: width of `nbytes`.
- `clk` in 1: single clock; all logic on posedge.
- `rst_L` in 1: reset, synchronous, active-low.
- `pktready` in 1: packet fields valid, request to send.
- `pause` in 1: downstream stall; freezes the encoder for that cycle.
- `pid` in 4: packet ID.
- `addr` in 7: token device address.
- `endp` in 4: token endpoint.
- `data` in 8*MAX_BYTES: payload, byte 0 in [7:0], sent first.
- `nbytes` in NB_W: payload length, 0..MAX_BYTES.
- `outb` out 1: serial bit.
- `sending` out 1: high while any packet bit or EOP is presented.
- `start` out 1: high during SYNC and PID.
- `eop` out 1: high during the two EOP bit-times.
- `gotpkt` out 1: one-cycle pulse when inputs are captured.

## Operation
- States: IDLE, LOAD, SYNC, PID, ADDR, ENDP, CRC5, PAYLOAD, CRC16, EOP.
- IDLE -> LOAD when `pktready`=1.
- LOAD, always one cycle:
  - `gotpkt`=1.
  - All inputs captured into internal registers.
  - Bit counter cleared.
  - CRC5 preset to 5'b11111, CRC16 preset to 16'hFFFF.
  - Next state SYNC.
- SYNC: 8 bits, 0,0,0,0,0,0,0,1.
- PID: 8 bits `{~pid,pid}`, LSB first. Next state by captured pid:
  - OUT 0001, IN 1001, SETUP 1101 -> ADDR.
  - DATA0 0011, DATA1 1011 -> PAYLOAD, or -> CRC16 if nbytes=0.
  - All other PIDs (ACK, NAK, STALL, reserved) -> EOP.
- ADDR: 7 bits, LSB first. ENDP: 4 bits, LSB first.
  - CRC5 (poly x^5+x^2+1) updates on each ADDR/ENDP bit as it is shifted out.
- CRC5: 5 bits of the complemented remainder, MSB first.
- PAYLOAD: nbytes*8 bits, byte 0 first, each byte LSB first.
  - CRC16 (poly 0x8005) updates per bit.
- CRC16: 16 bits of the complemented remainder, MSB first.
- EOP: two bit-times with `outb`=0, `eop`=1, `sending`=1. Then -> IDLE.
- `nbytes` > MAX_BYTES is clamped to MAX_BYTES at capture.
- `pktready` outside IDLE is ignored. Captured fields stay fixed for the whole packet even if the inputs change.
- Counter widths:
  - Bit counter sized for 8*MAX_BYTES-1.
  - Byte index = counter[high:3]; bit-in-byte = counter[2:0].

## Timing
- Reset values: `outb`=0, `sending`=0, `start`=0, `eop`=0, `gotpkt`=0, state=IDLE, CRC registers preset, counter 0.
- Latency: `pktready` sampled high in IDLE -> `gotpkt` in the next cycle (LOAD) -> first SYNC bit on `outb` the cycle after that.
- Every bit is presented for one or more cycles. The field/bit advances at a posedge only if `pause`=0 in that cycle.
  - While `pause`=1: `outb`, state, counters and CRCs hold.
  - `pause` has no effect in IDLE or LOAD.
- Field boundary: the last bit of a field and the first bit of the next field are on consecutive unpaused cycles, with no gap.
- Packet lengths in unpaused cycles, SYNC through EOP:
  - Handshake: 18.
  - Token: 34.
  - Data: 34 + 8*nbytes.
- Back-to-back packets: the earliest next `gotpkt` is 1 cycle after the last EOP cycle (IDLE then LOAD).
- `rst_L`=0 mid-packet: at the next posedge, go to IDLE, drop all outputs to 0, and discard the packet. No partial EOP.

## Test plan
- ACK, pid=4'b0010, no pause:
  - `outb` = 00000001, 01001011 (LSB-first `{~pid,pid}`), 0, 0 with `eop` on the last two bits.
  - `sending` high for exactly 18 cycles.
- OUT token, addr=7'h15, endp=4'hE:
  - After SYNC/PID, addr bits 1,0,1,0,1,0,0, then endp bits 0,1,1,1.
  - CRC5 bits match the reference model (expected 5'b10111, MSB first).
  - 34 sending cycles.
- DATA0 with nbytes=0:
  - PID followed directly by CRC16 = sixteen 0 bits, then EOP.
  - 34 sending cycles.
- DATA1, MAX_BYTES=8, nbytes=8, data=64'h0706050403020100:
  - Payload order byte 00 first, LSB first.
  - CRC16 matches the model.
  - 98 sending cycles.
  - Repeat with nbytes=12: the count is clamped to 8.
- Random `pause` (~40% duty) during the DATA packet:
  - The bit sequence, ignoring repeats, is identical to the no-pause run.
  - `outb` is stable across every paused cycle.
- Reset and capture checks:
  - `rst_L` low during PAYLOAD bit 20 -> all outputs 0 next cycle, state IDLE.
  - A following `pktready` completes a clean ACK.
  - Changing `pid`/`data` mid-packet does not affect the output.

Source files
------------

// File: rtl/usb_pkt_encoder.sv
// USB packet serialiser: SYNC, PID, token/payload fields, CRC5/CRC16 and EOP, LSB-first,
// one bit per unpaused clock, feeding the bit-stuffer/NRZI stage.
module usb_pkt_encoder #(
   parameter int unsigned MAX_BYTES = 8,
   parameter int unsigned NB_W      = $clog2(MAX_BYTES + 1)
) (
   input  logic                   clk,
   input  logic                   rst_L,
   input  logic                   pktready,
   input  logic                   pause,
   input  logic [3:0]             pid,
   input  logic [6:0]             addr,
   input  logic [3:0]             endp,
   input  logic [8*MAX_BYTES-1:0] data,
   input  logic [NB_W-1:0]        nbytes,
   output logic                   outb,
   output logic                   sending,
   output logic                   start,
   output logic                   eop,
   output logic                   gotpkt
);

   // At least 4 bits so the same counter can walk the 16 CRC16 bits.
   localparam int unsigned CntW = ($clog2(8 * MAX_BYTES) > 4) ? $clog2(8 * MAX_BYTES) : 4;

   typedef enum logic [3:0] {
      StIdle,
      StLoad,
      StSync,
      StPid,
      StAddr,
      StEndp,
      StCrc5,
      StPayload,
      StCrc16,
      StEop
   } state_e;

   state_e                 state_q, state_d;
   logic [CntW-1:0]        cnt_q, cnt_d;
   logic [4:0]             crc5_q, crc5_d;
   logic [15:0]            crc16_q, crc16_d;

   logic [3:0]             pid_q;
   logic [6:0]             addr_q;
   logic [3:0]             endp_q;
   logic [8*MAX_BYTES-1:0] data_q;
   logic [NB_W-1:0]        nbytes_q;

   logic                   capture;
   logic                   advance;
   logic                   field_last;
   state_e                 field_next;
   logic [NB_W-1:0]        nbytes_clamped;
   logic [7:0]             pid_byte;
   logic [2:0]             bit_idx;
   logic [CntW+3:0]        pay_bits;
   logic [CntW+3:0]        cnt_plus1;

   function automatic logic [4:0] crc5_step(input logic [4:0] crc, input logic din);
      logic fb;
      fb = crc[4] ^ din;
      return {crc[3:0], 1'b0} ^ (fb ? 5'h05 : 5'h00);
   endfunction

   function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
      logic fb;
      fb = crc[15] ^ din;
      return {crc[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
   endfunction

   assign advance        = ~pause;
   assign pid_byte       = {~pid_q, pid_q};
   assign bit_idx        = cnt_q[2:0];
   assign nbytes_clamped = (nbytes > NB_W'(MAX_BYTES)) ? NB_W'(MAX_BYTES) : nbytes;
   assign pay_bits       = {(CntW + 1)'(nbytes_q), 3'b000};
   assign cnt_plus1      = {4'b0000, cnt_q} + (CntW + 4)'(1);

   // Outputs are a pure function of the registered state, so they hold while paused.
   always_comb begin
      outb    = 1'b0;
      sending = 1'b0;
      start   = 1'b0;
      eop     = 1'b0;
      gotpkt  = 1'b0;
      unique case (state_q)
         StIdle: ;
         StLoad: gotpkt = 1'b1;
         StSync: begin
            sending = 1'b1;
            start   = 1'b1;
            outb    = (bit_idx == 3'd7);
         end
         StPid: begin
            sending = 1'b1;
            start   = 1'b1;
            outb    = pid_byte[bit_idx];
         end
         StAddr: begin
            sending = 1'b1;
            outb    = addr_q[bit_idx];
         end
         StEndp: begin
            sending = 1'b1;
            outb    = endp_q[cnt_q[1:0]];
         end
         StCrc5: begin
            sending = 1'b1;
            outb    = ~crc5_q[3'd4 - bit_idx];
         end
         StPayload: begin
            sending = 1'b1;
            outb    = data_q[cnt_q];
         end
         StCrc16: begin
            sending = 1'b1;
            outb    = ~crc16_q[4'd15 - cnt_q[3:0]];
         end
         StEop: begin
            sending = 1'b1;
            eop     = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      crc5_d     = crc5_q;
      crc16_d    = crc16_q;
      capture    = 1'b0;
      field_last = 1'b0;
      field_next = state_q;

      unique case (state_q)
         StIdle: begin
            if (pktready) state_d = StLoad;
         end
         StLoad: begin
            capture = 1'b1;
            cnt_d   = '0;
            crc5_d  = 5'h1f;
            crc16_d = 16'hffff;
            state_d = StSync;
         end
         StSync: begin
            field_last = (bit_idx == 3'd7);
            field_next = StPid;
         end
         StPid: begin
            field_last = (bit_idx == 3'd7);
            unique case (pid_q)
               4'b0001, 4'b1001, 4'b1101: field_next = StAddr;
               4'b0011, 4'b1011:          field_next = (nbytes_q == '0) ? StCrc16 : StPayload;
               default:                   field_next = StEop;
            endcase
         end
         StAddr: begin
            field_last = (cnt_q == CntW'(6));
            field_next = StEndp;
            if (advance) crc5_d = crc5_step(crc5_q, outb);
         end
         StEndp: begin
            field_last = (cnt_q == CntW'(3));
            field_next = StCrc5;
            if (advance) crc5_d = crc5_step(crc5_q, outb);
         end
         StCrc5: begin
            field_last = (cnt_q == CntW'(4));
            field_next = StEop;
         end
         StPayload: begin
            field_last = (cnt_plus1 == pay_bits);
            field_next = StCrc16;
            if (advance) crc16_d = crc16_step(crc16_q, outb);
         end
         StCrc16: begin
            field_last = (cnt_q == CntW'(15));
            field_next = StEop;
         end
         StEop: begin
            field_last = (cnt_q == CntW'(1));
            field_next = StIdle;
         end
         default: state_d = StIdle;
      endcase

      // Shared bit/field stepping for every serialising state.
      if (state_q != StIdle && state_q != StLoad && advance) begin
         if (field_last) begin
            state_d = field_next;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q + CntW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_L) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         crc5_q  <= 5'h1f;
         crc16_q <= 16'hffff;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         crc5_q  <= crc5_d;
         crc16_q <= crc16_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_L) begin
         pid_q    <= '0;
         addr_q   <= '0;
         endp_q   <= '0;
         data_q   <= '0;
         nbytes_q <= '0;
      end else if (capture) begin
         pid_q    <= pid;
         addr_q   <= addr;
         endp_q   <= endp;
         data_q   <= data;
         nbytes_q <= nbytes_clamped;
      end
   end

endmodule

// File: tb/tb_usb_pkt_encoder.sv
// Bench for usb_pkt_encoder: a packet-level bit-sequence model checked every cycle, plus
// literal expectations for known packets, pause, clamp, mid-packet reset and capture.
module tb_usb_pkt_encoder;

   localparam int unsigned MaxBytes = 8;

   logic                  clk = 1'b0;
   logic                  rst_L;
   logic                  pktready;
   logic                  pause;
   logic [3:0]            pid;
   logic [6:0]            addr;
   logic [3:0]            endp;
   logic [8*MaxBytes-1:0] data;
   logic [3:0]            nbytes;
   logic                  outb, sending, start, eop, gotpkt;

   usb_pkt_encoder #(.MAX_BYTES(MaxBytes)) dut (
      .clk     (clk),
      .rst_L   (rst_L),
      .pktready(pktready),
      .pause   (pause),
      .pid     (pid),
      .addr    (addr),
      .endp    (endp),
      .data    (data),
      .nbytes  (nbytes),
      .outb    (outb),
      .sending (sending),
      .start   (start),
      .eop     (eop),
      .gotpkt  (gotpkt)
   );

   always #5 clk = ~clk;

   int unsigned n_chk  = 0;
   int unsigned n_pass = 0;

   bit   exp_bit[$];
   bit   exp_st[$];
   bit   exp_eo[$];
   int   idx      = 0;
   int   send_cnt = 0;
   int   cap_n    = 0;
   logic [255:0] cap_v;
   logic [255:0] ref_v;
   bit   chk_en   = 1'b0;
   bit   prev_paused = 1'b0;
   logic prev_outb   = 1'b0;

   task automatic chk(input bit ok, input string name, input logic [63:0] act,
                      input logic [63:0] expv);
      n_chk++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
   endtask

   function automatic logic [4:0] model_crc5(input logic [10:0] v);
      logic [4:0] r = 5'h1f;
      for (int i = 0; i < 11; i++) begin
         logic fb = r[4] ^ v[i];
         r = {r[3:0], 1'b0};
         if (fb) r = r ^ 5'h05;
      end
      return ~r;
   endfunction

   function automatic logic [15:0] model_crc16(input logic [8*MaxBytes-1:0] d, input int n);
      logic [15:0] r = 16'hffff;
      for (int i = 0; i < 8 * n; i++) begin
         logic fb = r[15] ^ d[i];
         r = {r[14:0], 1'b0};
         if (fb) r = r ^ 16'h8005;
      end
      return ~r;
   endfunction

   task automatic push(input bit b, input bit st, input bit eo);
      exp_bit.push_back(b);
      exp_st.push_back(st);
      exp_eo.push_back(eo);
   endtask

   // Expected line sequence of one whole packet, SYNC through EOP.
   task automatic build(input logic [3:0] p, input logic [6:0] a, input logic [3:0] e,
                        input logic [8*MaxBytes-1:0] d, input int nb);
      logic [7:0]  pb;
      logic [10:0] tok;
      logic [4:0]  c5;
      logic [15:0] c16;
      int          n;
      exp_bit.delete();
      exp_st.delete();
      exp_eo.delete();
      pb = {~p, p};
      for (int i = 0; i < 8; i++) push(i == 7, 1'b1, 1'b0);
      for (int i = 0; i < 8; i++) push(pb[i], 1'b1, 1'b0);
      if (p == 4'b0001 || p == 4'b1001 || p == 4'b1101) begin
         tok = {e, a};
         c5  = model_crc5(tok);
         for (int i = 0; i < 11; i++) push(tok[i], 1'b0, 1'b0);
         for (int i = 4; i >= 0; i--) push(c5[i], 1'b0, 1'b0);
      end else if (p == 4'b0011 || p == 4'b1011) begin
         n   = (nb > MaxBytes) ? MaxBytes : nb;
         c16 = model_crc16(d, n);
         for (int i = 0; i < 8 * n; i++) push(d[i], 1'b0, 1'b0);
         for (int i = 15; i >= 0; i--) push(c16[i], 1'b0, 1'b0);
      end
      push(1'b0, 1'b0, 1'b1);
      push(1'b0, 1'b0, 1'b1);
   endtask

   // Compare process: outputs are sampled on the falling edge; pause seen here is the value
   // the next rising edge will use, so the model index advances only when it is low.
   always @(negedge clk) begin
      if (chk_en) begin
         if (sending === 1'b1) begin
            if (idx >= exp_bit.size()) begin
               chk(1'b0, "sending_overrun", 64'(idx), 64'(exp_bit.size()));
            end else begin
               chk(outb === exp_bit[idx], "outb", 64'(outb), 64'(exp_bit[idx]));
               chk(start === exp_st[idx], "start", 64'(start), 64'(exp_st[idx]));
               chk(eop === exp_eo[idx], "eop", 64'(eop), 64'(exp_eo[idx]));
            end
            if (prev_paused) chk(outb === prev_outb, "pause_hold", 64'(outb), 64'(prev_outb));
            send_cnt++;
            if (pause === 1'b0) begin
               cap_v[cap_n] = outb;
               cap_n++;
               idx++;
            end
            prev_paused = (pause === 1'b1);
            prev_outb   = outb;
         end else begin
            chk(outb === 1'b0 && start === 1'b0 && eop === 1'b0, "idle_outputs",
                64'({outb, start, eop}), 64'(0));
            prev_paused = 1'b0;
         end
      end
   end

   // Called at posedge+#1 with the DUT idle; returns at posedge+#1 right after the last EOP.
   task automatic send(input logic [3:0] p, input logic [6:0] a, input logic [3:0] e,
                       input logic [8*MaxBytes-1:0] d, input int nb, input bit pmode,
                       input bit mutate, input int exp_len);
      bit done = 1'b0;
      build(p, a, e, d, nb);
      idx      = 0;
      cap_n    = 0;
      send_cnt = 0;
      cap_v    = '0;
      pid      = p;
      addr     = a;
      endp     = e;
      data     = d;
      nbytes   = 4'(nb);
      pktready = 1'b1;
      pause    = pmode ? ($urandom_range(0, 99) < 40) : 1'b0;
      @(negedge clk);
      chk(gotpkt === 1'b0, "gotpkt_idle", 64'(gotpkt), 64'(0));
      @(posedge clk);
      #1;
      pktready = 1'b0;
      pause    = pmode ? ($urandom_range(0, 99) < 40) : 1'b0;
      @(negedge clk);
      chk(gotpkt === 1'b1, "gotpkt_load", 64'(gotpkt), 64'(1));
      for (int c = 0; c < 2000 && !done; c++) begin
         @(posedge clk);
         #1;
         if (c == 0 && mutate) begin
            pid  = ~p;
            data = ~d;
            addr = ~a;
         end
         if (idx >= exp_bit.size()) done = 1'b1;
         else pause = pmode ? ($urandom_range(0, 99) < 40) : 1'b0;
      end
      pause = 1'b0;
      chk(done, "packet_done", 64'(idx), 64'(exp_bit.size()));
      if (exp_len != 0) chk(send_cnt == exp_len, "sending_cycles", 64'(send_cnt), 64'(exp_len));
   endtask

   logic [8*MaxBytes-1:0] d_seq;
   bit                    hit;

   initial begin
      d_seq    = 64'h0706050403020100;
      rst_L    = 1'b0;
      pktready = 1'b0;
      pause    = 1'b0;
      pid      = '0;
      addr     = '0;
      endp     = '0;
      data     = '0;
      nbytes   = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk({outb, sending, start, eop, gotpkt} === 5'b0, "reset_outputs",
          64'({outb, sending, start, eop, gotpkt}), 64'(0));
      @(posedge clk);
      #1;
      rst_L  = 1'b1;
      chk_en = 1'b1;

      // ACK handshake.
      send(4'b0010, 7'h00, 4'h0, '0, 0, 1'b0, 1'b0, 18);
      chk(cap_v[17:0] == {2'b00, 8'hD2, 8'h80}, "ack_bits", 64'(cap_v[17:0]),
          64'({2'b00, 8'hD2, 8'h80}));

      // OUT token, back to back with the ACK.
      send(4'b0001, 7'h15, 4'hE, '0, 0, 1'b0, 1'b0, 34);
      chk(cap_v[15:0] == 16'hE180, "out_sync_pid", 64'(cap_v[15:0]), 64'(16'hE180));
      chk(cap_v[26:16] == {4'hE, 7'h15}, "out_addr_endp", 64'(cap_v[26:16]),
          64'({4'hE, 7'h15}));
      chk(cap_v[31:27] == 5'b11101, "out_crc5", 64'(cap_v[31:27]), 64'(5'b11101));

      // DATA0, empty payload: CRC16 of nothing is all zero on the line.
      send(4'b0011, 7'h00, 4'h0, '0, 0, 1'b0, 1'b0, 34);
      chk(cap_v[15:0] == 16'hC380, "data0_sync_pid", 64'(cap_v[15:0]), 64'(16'hC380));
      chk(cap_v[31:16] == 16'h0000, "data0_crc16", 64'(cap_v[31:16]), 64'(0));

      // DATA1, full payload.
      send(4'b1011, 7'h00, 4'h0, d_seq, 8, 1'b0, 1'b0, 98);
      chk(cap_v[79:16] == d_seq, "data1_payload", cap_v[79:16], d_seq);
      ref_v = cap_v;

      // Oversized length is clamped.
      send(4'b1011, 7'h00, 4'h0, d_seq, 12, 1'b0, 1'b0, 98);
      chk(cap_v[97:0] == ref_v[97:0], "clamp_bits", 64'(cap_v[97:34]), 64'(ref_v[97:34]));

      // Random pause and mid-packet input changes.
      send(4'b1011, 7'h00, 4'h0, d_seq, 8, 1'b1, 1'b1, 0);
      chk(cap_n == 98, "pause_len", 64'(cap_n), 64'(98));
      chk(cap_v[97:0] == ref_v[97:0], "pause_bits", 64'(cap_v[97:34]), 64'(ref_v[97:34]));

      // Other tokens, handshakes and a short payload.
      send(4'b1101, 7'h7F, 4'h0, '0, 0, 1'b1, 1'b0, 0);
      send(4'b1110, 7'h00, 4'h0, '0, 0, 1'b0, 1'b0, 18);
      send(4'b0011, 7'h00, 4'h0, 64'h00000000_00C0FFEE, 3, 1'b0, 1'b0, 58);

      // Reset during payload bit 20 discards the packet.
      build(4'b1011, 7'h00, 4'h0, d_seq, 8);
      idx      = 0;
      pid      = 4'b1011;
      data     = d_seq;
      nbytes   = 4'd8;
      pktready = 1'b1;
      @(posedge clk);
      #1;
      pktready = 1'b0;
      hit = 1'b0;
      for (int c = 0; c < 200 && !hit; c++) begin
         @(posedge clk);
         #1;
         if (idx == 36) hit = 1'b1;
      end
      chk(hit, "reached_payload_bit20", 64'(idx), 64'(36));
      rst_L = 1'b0;
      @(posedge clk);
      #1;
      rst_L = 1'b1;
      exp_bit.delete();
      exp_st.delete();
      exp_eo.delete();
      idx = 0;
      @(negedge clk);
      chk({outb, sending, start, eop, gotpkt} === 5'b0, "reset_midpacket",
          64'({outb, sending, start, eop, gotpkt}), 64'(0));
      @(posedge clk);
      #1;

      // Clean ACK after the abort.
      send(4'b0010, 7'h00, 4'h0, '0, 0, 1'b0, 1'b0, 18);
      chk(cap_v[17:0] == {2'b00, 8'hD2, 8'h80}, "ack_after_reset", 64'(cap_v[17:0]),
          64'({2'b00, 8'hD2, 8'h80}));

      repeat (2) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
